// File: rtl/mem_rmw_controller.sv
// mem_rmw_controller: sub-word load/store sequencer on top of a 32-bit
// word-only data memory (combinational read, synchronous whole-word write).
// Byte/halfword stores are done as read-modify-write; loads are extended.
// Optional feature macro: MEM_RMW_ALIGN_CHECK_EN -- when defined, misaligned
// halfword/word requests are rejected; otherwise low address bits are
// forced to natural alignment.
module mem_rmw_controller #(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MERGE,
        ST_WRITE,
        ST_RESP
    } state_t;

    state_t      state_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        acc_err_d;
    logic [31:0] acc_addr_d;
    logic [31:0] load_d;
    logic [31:0] merge_d;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Classify the incoming request: legality and the address to latch.
    always_comb begin
        acc_addr_d = req_addr;
        acc_err_d  = (req_size == 2'b11) || (req_addr >= MEM_BYTES);
`ifdef MEM_RMW_ALIGN_CHECK_EN
        if (req_size == 2'b01 && req_addr[0]) begin
            acc_err_d = 1'b1;
        end
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00) begin
            acc_err_d = 1'b1;
        end
`else
        if (req_size == 2'b01) begin
            acc_addr_d[0] = 1'b0;
        end
        if (req_size == 2'b10) begin
            acc_addr_d[1:0] = 2'b00;
        end
`endif
    end

    // Select the addressed lane from the memory word and extend it for loads.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_byte = mem_rdata[7:0];
            2'd1:    lane_byte = mem_rdata[15:8];
            2'd2:    lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
        lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   load_d = uns_q ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            2'b01:   load_d = uns_q ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
            default: load_d = mem_rdata;
        endcase
    end

    // Overlay the store data onto the current memory word for sub-word stores.
    always_comb begin
        merge_d = mem_rdata;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merge_d[7:0]   = wdata_q[7:0];
                2'd1:    merge_d[15:8]  = wdata_q[7:0];
                2'd2:    merge_d[23:16] = wdata_q[7:0];
                default: merge_d[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merge_d[31:16] = wdata_q[15:0];
        end else begin
            merge_d[15:0] = wdata_q[15:0];
        end
    end

    // Request sequencer: accept, access memory, hold the response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= acc_addr_d;
                        wdata_q <= req_wdata;
                        rdata_q <= '0;
                        err_q   <= acc_err_d;
                        if (acc_err_d) begin
                            state_q <= ST_RESP;
                        end else if (!req_we) begin
                            state_q <= ST_LOAD;
                        end else if (req_size == 2'b10) begin
                            state_q <= ST_WRITE;
                        end else begin
                            state_q <= ST_MERGE;
                        end
                    end
                end
                ST_LOAD: begin
                    rdata_q <= load_d;
                    state_q <= ST_RESP;
                end
                ST_MERGE: begin
                    wdata_q <= merge_d;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Write enable is a pure state decode so an asynchronous reset kills it at once.
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign mem_we    = (state_q == ST_WRITE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_rmw_controller.sv
// Directed bench for mem_rmw_controller with a scoreboard of expected
// responses and a behavioural word memory.
module tb_mem_rmw_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    logic        mem_clr = 1'b1;
    int          we_cnt = 0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    mem_rmw_controller #(.MEM_BYTES(256)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for its response, compare with the scoreboard.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_writes);
        exp_t e;
        int   lat;
        int   w0;
        sb.push_back('{rdata: exp_rdata, err: exp_err, lat: exp_lat});
        @(negedge clk);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        w0 = we_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        e = sb.pop_front();
        if (!rsp_valid) begin
            chk({tag, ".timeout"}, 32'(rsp_valid), 32'd1);
        end else begin
            chk({tag, ".rdata"}, rsp_rdata, e.rdata);
            chk({tag, ".err"}, 32'(rsp_err), 32'(e.err));
            chk({tag, ".lat"}, 32'(lat), 32'(e.lat));
        end
        @(posedge clk);
        #1;
        chk({tag, ".writes"}, 32'(we_cnt - w0), 32'(exp_writes));
    endtask

    initial begin
        exp_t e;
        int   n;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        chk("rst.rsp_err", 32'(rsp_err), 32'd0);
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_clr = 1'b0;

        // Word store/load, sub-word RMW, and extension.
        do_req("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
        chk("sw10.mem", mem[4], 32'hDEADBEEF);
        do_req("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
        do_req("sb11", 1'b1, 2'b00, 1'b0, 32'h11, 32'hAABBCC55, 32'h0, 1'b0, 3, 1);
        chk("sb11.mem", mem[4], 32'hDEAD55EF);
        do_req("lb13s", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 0);
        do_req("lb13u", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2, 0);
        do_req("sh12", 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, 32'h0, 1'b0, 3, 1);
        chk("sh12.mem", mem[4], 32'h123455EF);
        do_req("lh12s", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h00001234, 1'b0, 2, 0);
        do_req("lb10s", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 2, 0);
        do_req("lb11u", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h00000055, 1'b0, 2, 0);

        // Error requests: out of range, reserved size (load and store).
        do_req("lw100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("lsz3", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("ssz3", 1'b1, 2'b11, 1'b0, 32'h0, 32'h77777777, 32'h0, 1'b1, 1, 0);
        chk("ssz3.mem", mem[0], 32'h0);

        // Back-pressure: response held stable, no new request accepted.
        rsp_ready = 1'b0;
        sb.push_back('{rdata: 32'h123455EF, err: 1'b0, lat: 2});
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        e = sb.pop_front();
        chk("bp.rdata", rsp_rdata, e.rdata);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp.valid", 32'(rsp_valid), 32'd1);
            chk("bp.hold", rsp_rdata, e.rdata);
            chk("bp.req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp.release", 32'(rsp_valid), 32'd0);
        chk("bp.idle", 32'(req_ready), 32'd1);

        // Misaligned word store: rejected with the check, aligned down without it.
`ifdef MEM_RMW_ALIGN_CHECK_EN
        do_req("sw11", 1'b1, 2'b10, 1'b0, 32'h11, 32'hCAFEF00D, 32'h0, 1'b1, 1, 0);
        chk("sw11.mem", mem[4], 32'h123455EF);
`else
        do_req("sw11", 1'b1, 2'b10, 1'b0, 32'h11, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1);
        chk("sw11.mem", mem[4], 32'hCAFEF00D);
`endif

        // Reset while in WRITE: the write must be aborted.
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20;
        req_wdata = 32'h11111111; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("rstw.in_write", 32'(mem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstw.mem_we", 32'(mem_we), 32'd0);
        chk("rstw.req_ready", 32'(req_ready), 32'd1);
        chk("rstw.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstw.mem_addr", mem_addr, 32'd0);
        chk("rstw.mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstw.mem", mem[8], 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("rstw.no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("rstw.mem_after", mem[8], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_rmw_controller.md
# mem_rmw_controller

Load/store sequencer between the core's LSU and the 32-bit word-only data memory. The memory reads combinationally and writes whole words on the clock edge, so this block provides sub-word access on top of it. It turns byte, halfword and word load/store requests into word accesses, performs read-modify-write for sub-word stores and sign/zero-extends loads. It also flags illegal requests.

## Interface
- MEM_BYTES, 256: data memory size in bytes; byte addresses >= MEM_BYTES are out of range.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected; no memory write occurred.
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_wdata  out  32  full word to write.
- mem_we  out  1  memory write enable.
- mem_rdata  in  32  combinational read data at mem_addr.

## Operation
- States: IDLE, LOAD, MERGE, WRITE, RESP.
- IDLE: req_ready=1. Accept on req_valid&req_ready at a rising edge. Latch we, size, unsigned, addr and wdata.
- Accepted request, next state:
  - Error: RESP with err=1.
  - Load: LOAD.
  - Word store: WRITE with wdata as-is.
  - Byte or halfword store: MERGE.
- Error conditions: req_size=11, req_addr >= MEM_BYTES, or misalignment (see Configuration).
- LOAD: drive mem_addr and sample mem_rdata. Byte lane = addr[1:0], halfword lane = addr[1]. Extend per the unsigned flag into rsp_rdata, then go to RESP.
- MERGE: drive mem_addr. Register mem_rdata with the target lane(s) replaced by wdata[7:0] or wdata[15:0], then go to WRITE.
- WRITE: mem_we=1 and mem_wdata = the merged or full word. The memory commits at the edge leaving WRITE. Then go to RESP.
- RESP: rsp_valid=1 and rsp_rdata/rsp_err stay stable until rsp_ready, then return to IDLE. No new request is accepted in the same cycle as the response handshake.
- Byte lanes are little-endian: byte k occupies bits [8k+7:8k].
- mem_we is decoded from state==WRITE only. mem_addr holds the latched address outside IDLE.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Latency from the accept edge to the first cycle rsp_valid=1:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Throughput: at most one request per 3 cycles (loads and word stores) or per 4 cycles (sub-word stores) with rsp_ready=1.
- Back-pressure: rsp_ready=0 holds RESP indefinitely with the response unchanged. req_ready stays 0.
- Reset mid-operation: rst_n low forces IDLE immediately and drops mem_we before the next edge, so a WRITE in progress is aborted with no memory write. Any latched request is discarded and no response is produced.
- req_valid seen outside IDLE is ignored; the requester holds it until req_ready.
- Store then load to the same word: the load observes the stored data because the write commits before the next accept.

## Configuration
- MEM_RMW_ALIGN_CHECK_EN defined:
  - Halfword with addr[0]=1 is an error.
  - Word with addr[1:0]!=0 is an error.
  - Error responses perform no memory access.
- Not defined:
  - Low address bits are forced to natural alignment: halfword clears addr[0], word clears addr[1:0].
  - No misalignment error is raised. Size 11 and out-of-range still report rsp_err.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid exactly 2 cycles after each accept.
- After that, byte store 0x55 @0x11 -> memory word 0x10 = 0xDEAD55EF. Signed byte load @0x13 -> 0xFFFFFFDE; unsigned -> 0x000000DE.
- Halfword store 0x1234 @0x12 -> word = 0x123455EF. Signed halfword load @0x12 -> 0x00001234; response 3 cycles after the store accept.
- With MEM_RMW_ALIGN_CHECK_EN: word store @0x11 -> rsp_err=1 one cycle after accept and the word is unchanged. Without the macro: same request writes word 0x10.
- Word load @0x100 with MEM_BYTES=256, and req_size=11 @0x0 -> rsp_err=1, rsp_rdata=0, mem_we never asserted.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable and req_ready=0 throughout. Assert rst_n low during WRITE -> mem_we=0 immediately, word unchanged, outputs at reset values.
